imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Sequences instruction-memory reads for the multicycle core: owns the PC, drives the
//  instruction-memory address, waits out the memory's fixed access delay, and captures the word
//  into an instruction register. Presents the instruction to the control unit with a valid/ready
//  handshake and accepts branch/jump redirects. Sits between the instruction memory and the
//  control FSM / datapath.
// PARAMETERS
//  ADDR_W    32  PC / memory address width in bits.
//  DATA_W    32  instruction width in bits.
//  MEM_LAT   2   clock cycles from address stable to imem_rdata valid; legal range >= 1.
//  RESET_PC  0   PC value loaded on reset; must be word-aligned.
// PORTS
//  clk             in   1       core clock; all state updates on rising edge.
//  reset           in   1       synchronous, active-high reset.
//  imem_addr       out  ADDR_W  byte address to instruction memory; always equals pc.
//  imem_rdata      in   DATA_W  instruction word returned by memory.
//  halt            in   1       1 = do not start new fetches; the in-flight fetch completes.
//  instr_valid     out  1       ir/instr_pc hold a fetched instruction.
//  instr_ready     in   1       control unit consumes instruction when instr_valid && instr_ready.
//  instr           out  DATA_W  instruction register (ir).
//  instr_pc        out  ADDR_W  address the presented instruction was fetched from.
//  redirect_valid  in   1       1-cycle request to fetch from redirect_pc next.
//  redirect_pc     in   ADDR_W  branch/jump target, byte address.
//  align_err       out  1       1-cycle pulse: misaligned redirect rejected (see CONFIGURATION).
// BEHAVIOUR
//  - Reset (sync, active-high): pc=RESET_PC, state=ISSUE, instr_valid=0, instr=0, instr_pc=0,
//    align_err=0, wait count=0. Reset asserted mid-fetch abandons the fetch; no output glitches
//    past the reset edge.
//  - States:
//    - ISSUE: imem_addr=pc. If !halt, load cnt=MEM_LAT-1 and go to WAIT; else stay.
//    - WAIT: if cnt==0, ir<=imem_rdata, instr_pc<=pc, go to VALID; else cnt--.
//    - VALID: instr_valid=1. On instr_ready: pc<=pc+4 and go to ISSUE.
//  - Latency: instr_valid rises exactly MEM_LAT+1 cycles after ISSUE entry with halt=0.
//  - pc is stable for the whole ISSUE..WAIT window. instr and instr_pc are stable while
//    instr_valid=1.
//  - instr_valid is a registered state decode: 0 in ISSUE and WAIT, 1 in VALID.
//  - Redirect (highest priority, any state): pc<=redirect_pc; next state is ISSUE;
//    instr_valid=0 the next cycle.
//    - In-flight fetch in WAIT: discarded; ir is not updated.
//    - Redirect in VALID with instr_ready the same cycle: the handshake completes (the instruction
//      is consumed), and the next pc is redirect_pc, not pc+4.
//    - Redirect while halt=1: pc is updated; the fetch starts once halt drops.
//  - pc+4 wraps modulo 2^ADDR_W; no error is raised.
//  - halt has no effect in WAIT or VALID.
// CONFIGURATION
//  Macro IMEM_FETCH_ALIGN_CHECK_EN:
//  - Defined: a redirect with redirect_pc[1:0]!=0 is rejected. pc, state and any in-flight fetch
//    are unaffected, and align_err pulses high for exactly 1 cycle (registered).
//  - Undefined: redirect_pc[1:0] is forced to 2'b00 on load; align_err is tied 0.
// STRUCTURE
//  - Package imem_fetch_pkg: state encoding (ISSUE=2'd0, WAIT=2'd1, VALID=2'd2) and WORD_BYTES=4.
//  - One sub-module, imem_lat_timer: MEM_LAT down-counter with load/clear/done ports. It is
//    cleared by reset and by redirect.
//  - Everything else is a single always block for state/pc/ir plus a registered
//    align_err pulse.
// TESTING
//  Bench: MEM_LAT=2 memory model with word i = 32'hA000_0000+i.
//  1. Reset, instr_ready=1: instr_valid at cycles 3, 7, 11 (every 4 cycles);
//     instr=A0000000, A0000001, ...; instr_pc=0, 4, 8.
//  2. Hold instr_ready=0 for 5 cycles in VALID: instr and instr_pc stay constant and pc stays
//     unchanged; on release, the next fetch is from pc+4.
//  3. Redirect to 0x40 during WAIT: the old word is never presented; next valid shows
//     instr=A0000010, instr_pc=0x40 after 3 cycles.
//  4. Redirect to 0x80 together with instr_ready in VALID: the current word is consumed; the next
//     instr_pc is 0x80, not pc+4.
//  5. halt=1 in ISSUE for 4 cycles, then 0: no WAIT entry while halted; valid 3 cycles after
//     release.
//  6. With IMEM_FETCH_ALIGN_CHECK_EN: redirect to 0x42 gives a 1-cycle align_err and the fetch
//     sequence is unchanged. Without the macro: the fetch is from 0x40 and align_err stays 0.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// Shared definitions for the instruction fetch controller: fetch state encoding and word size.
package imem_fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_lat_timer.sv
// Down-counter that times out the instruction memory access delay.
// Clear has priority over load; done is high while the count is zero.
module imem_lat_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, waits out the memory delay, presents the IR via valid/ready.
// Optional misaligned-redirect rejection is enabled by defining IMEM_FETCH_ALIGN_CHECK_EN.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                MEM_LAT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              halt,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              align_err
);

  localparam int                CNT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0]  LAT_LOAD   = CNT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(WORD_BYTES);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              redir_take;
  logic [ADDR_W-1:0] redir_target;
  logic              timer_load;
  logic              timer_dec;
  logic              timer_done;

`ifdef IMEM_FETCH_ALIGN_CHECK_EN
  logic redir_bad;

  assign redir_bad    = redirect_valid && ((redirect_pc & ALIGN_MASK) != '0);
  assign redir_take   = redirect_valid && !redir_bad;
  assign redir_target = redirect_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      align_err <= 1'b0;
    end else begin
      align_err <= redir_bad;
    end
  end
`else
  assign redir_take   = redirect_valid;
  assign redir_target = redirect_pc & ~ALIGN_MASK;
  assign align_err    = 1'b0;
`endif

  assign imem_addr  = pc;
  assign timer_load = (state == ISSUE) && !halt;
  assign timer_dec  = (state == WAIT);

  imem_lat_timer #(
    .CNT_W (CNT_W)
  ) u_lat_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (redir_take),
    .load     (timer_load),
    .load_val (LAT_LOAD),
    .dec      (timer_dec),
    .done     (timer_done)
  );

  // A redirect overrides every state; in VALID with instr_ready the word is still
  // consumed, so only the pc source changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else if (redir_take) begin
      state       <= ISSUE;
      pc          <= redir_target;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          if (!halt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (timer_done) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (instr_ready) begin
            pc          <= pc + PC_STEP;
            instr_valid <= 1'b0;
            state       <= ISSUE;
          end
        end
        default: begin
          state       <= ISSUE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus randomized traffic against a
// cycle-age reference model; memory returns word 32'hA000_0000 + (addr >> 2) after 2 cycles.
module tb_imem_fetch_ctrl;

  localparam int MEM_LAT = 2;
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        align_err;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MEM_LAT  (MEM_LAT),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .halt           (halt),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .align_err      (align_err)
  );

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return 32'hA000_0000 + (addr >> 2);
  endfunction

  // Memory: data for an address appears MEM_LAT cycles after the address is presented.
  logic [31:0] mem_p1, mem_p2;
  always @(posedge clk) begin
    mem_p1 <= imem_addr;
    mem_p2 <= mem_p1;
  end
  assign imem_rdata = word_at(mem_p2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: age counts cycles since the fetch was issued (0 = waiting to issue).
  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_valid, m_err, m_bad;
  int          m_age;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
      m_valid = 1'b0; m_err = 1'b0; m_age = 0;
    end else begin
      m_bad = ALIGN_CHK && redirect_valid && (redirect_pc[1:0] != 2'b00);
      m_err = m_bad;
      if (redirect_valid && !m_bad) begin
        m_pc    = ALIGN_CHK ? redirect_pc : {redirect_pc[31:2], 2'b00};
        m_valid = 1'b0;
        m_age   = 0;
      end else if (m_valid) begin
        if (instr_ready) begin
          m_pc    = m_pc + 32'd4;
          m_valid = 1'b0;
          m_age   = 0;
        end
      end else if (m_age == 0) begin
        if (!halt) m_age = 1;
      end else if (m_age == MEM_LAT) begin
        m_valid = 1'b1;
        m_instr = word_at(m_pc);
        m_ipc   = m_pc;
      end else begin
        m_age++;
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
      chk("align_err", {31'b0, align_err}, {31'b0, m_err});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_valid_after(input int n, input logic [31:0] pc, input logic [31:0] data);
    for (int i = 1; i <= n; i++) begin
      step();
      if (i < n) begin
        chk("dir_not_valid_yet", {31'b0, instr_valid}, 32'd0);
      end else begin
        chk("dir_valid", {31'b0, instr_valid}, 32'd1);
        chk("dir_instr", instr, data);
        chk("dir_instr_pc", instr_pc, pc);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; halt = 1'b0; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) step();
    chk_en = 1'b1;
    chk("reset_valid", {31'b0, instr_valid}, 32'd0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_addr", imem_addr, 32'h0);
    reset = 1'b0;

    // back-to-back fetches with ready held high
    expect_valid_after(3, 32'h0, 32'hA000_0000);
    expect_valid_after(4, 32'h4, 32'hA000_0001);
    expect_valid_after(4, 32'h8, 32'hA000_0002);

    // consumer stalls for 5 cycles in VALID
    step();
    instr_ready = 1'b0;
    expect_valid_after(3, 32'hC, 32'hA000_0003);
    repeat (4) begin
      step();
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'hA000_0003);
      chk("stall_instr_pc", instr_pc, 32'hC);
      chk("stall_addr", imem_addr, 32'hC);
    end
    instr_ready = 1'b1;
    step();
    chk("release_addr", imem_addr, 32'h10);
    expect_valid_after(3, 32'h10, 32'hA000_0004);

    // redirect while waiting on memory
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("wait_redir_addr", imem_addr, 32'h40);
    chk("wait_redir_valid", {31'b0, instr_valid}, 32'd0);
    expect_valid_after(3, 32'h40, 32'hA000_0010);

    // redirect coinciding with the handshake
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    chk("valid_redir_addr", imem_addr, 32'h80);
    expect_valid_after(3, 32'h80, 32'hA000_0020);

    // halt in ISSUE
    halt = 1'b1;
    repeat (5) begin
      step();
      chk("halt_addr", imem_addr, 32'h84);
      chk("halt_valid", {31'b0, instr_valid}, 32'd0);
    end
    halt = 1'b0;
    expect_valid_after(3, 32'h84, 32'hA000_0021);

    // misaligned redirect
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
    chk("misalign_err", {31'b0, align_err}, 32'd1);
    chk("misalign_addr", imem_addr, 32'h88);
    step();
    chk("misalign_err_drop", {31'b0, align_err}, 32'd0);
    expect_valid_after(1, 32'h88, 32'hA000_0022);
`else
    chk("misalign_err", {31'b0, align_err}, 32'd0);
    chk("misalign_addr", imem_addr, 32'h40);
    expect_valid_after(3, 32'h40, 32'hA000_0010);
`endif

    // randomized traffic, including wrap-around targets and occasional reset
    for (int i = 0; i < 4000; i++) begin
      step();
      instr_ready    = ($urandom_range(0, 3) != 0);
      halt           = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom_range(0, 255);
        1:       redirect_pc = 32'hFFFF_FF00 + $urandom_range(0, 255);
        2:       redirect_pc = 32'hFFFF_FFFC;
        default: redirect_pc = $urandom;
      endcase
      reset = ($urandom_range(0, 299) == 0);
    end
    step();
    reset = 1'b0; redirect_valid = 1'b0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
